// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator.
package router_pkg;

  // Generator FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Header field layout: destination address in the low bits, then the
  // low bits of the payload length.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;

  // Address value the router must drop; it is transmitted unchanged.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR accumulator over the words of one packet.
// clear has priority over enable; parity is the registered XOR of all
// enabled data words since the last clear.
module router_parity_acc #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] parity
);

  // Accumulate XOR of each enabled word; restart at the beginning of a packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       parity <= '0;
    else if (clear)  parity <= '0;
    else if (enable) parity <= parity ^ data;
  end

endmodule

// File: rtl/router_pkt_gen.sv
// Upstream packet source: serialises header, payload words and a trailing
// parity word onto data_in/pkt_valid, stalls on busy, counts err rising edges.
//
// Handshakes:
//   request : a request is taken on a rising edge where req_valid && req_ready;
//             req_ready is high only in IDLE, and nothing is queued otherwise.
//   router  : the word on data_in is taken on a rising edge where busy=0 in
//             HDR/PAY/PAR; while busy=1 data_in and pkt_valid hold their value.
//
// Optional build macro ROUTER_PKT_GEN_CORRUPT_EN adds input req_corrupt; when
// captured high with a request, bit 0 of that packet's parity word is inverted.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int DATA_W = 3,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_seed,
`ifdef ROUTER_PKT_GEN_CORRUPT_EN
  input  logic              req_corrupt,
`endif
  output logic [DATA_W-1:0] data_in,
  output logic              pkt_valid,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  err_cnt,
  output state_t            fsm_state
);

  state_t              state;
  logic [LEN_W-1:0]    remaining;
  logic [DATA_W-1:0]   next_word;
  logic [DATA_W-1:0]   header;
  logic [DATA_W-1:0]   parity;
  logic [DATA_W-1:0]   parity_word;
  logic                corrupt_q;
  logic                err_q;
  logic                accept;
  logic                take;

  assign accept    = req_valid && (state == IDLE);
  // A header or payload word currently on data_in is consumed this edge.
  assign take      = !busy && ((state == HDR) || (state == PAY));
  assign req_ready = (state == IDLE);
  assign fsm_state = state;

  // Final parity folds in the last word, which the accumulator sees only
  // on the same edge that loads the parity word.
  assign parity_word = parity ^ data_in ^ {{(DATA_W-1){1'b0}}, corrupt_q};

  // Header word built from the live request fields, loaded on acceptance.
  always_comb begin
    header = '0;
    header[ADDR_LSB +: ADDR_W]  = req_addr;
    header[DATA_W-1:ADDR_W]     = req_len[DATA_W-3:0];
  end

`ifdef ROUTER_PKT_GEN_CORRUPT_EN
  // Capture the error-injection request together with the packet request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       corrupt_q <= 1'b0;
    else if (accept) corrupt_q <= req_corrupt;
  end
`else
  assign corrupt_q = 1'b0;
`endif

  router_parity_acc #(.W(DATA_W)) u_parity_acc (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (take),
    .data   (data_in),
    .parity (parity)
  );

  // Packet FSM with registered word, valid and done outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_in   <= '0;
      pkt_valid <= 1'b0;
      pkt_done  <= 1'b0;
      remaining <= '0;
      next_word <= '0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= HDR;
            data_in   <= header;
            pkt_valid <= 1'b1;
            remaining <= req_len;
            next_word <= req_seed;
          end
        end
        HDR, PAY: begin
          if (!busy) begin
            if (remaining == '0) begin
              state     <= PAR;
              data_in   <= parity_word;
              pkt_valid <= 1'b0;
            end else begin
              state     <= PAY;
              data_in   <= next_word;
              next_word <= next_word + 1'b1;
              remaining <= remaining - 1'b1;
            end
          end
        end
        PAR: begin
          if (!busy) begin
            state    <= GAP;
            data_in  <= '0;
            pkt_done <= 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          data_in   <= '0;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of err rising edges, active in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= err;
      if (err && !err_q && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
